// File: rtl/ffa.sv
// Limb-serial modular adder over GF(2^255 - 19): result = (a + b) mod p, with one conditional subtract.
// Define FFA_HOLD_VALID_EN to hold valid/result until an ack handshake instead of pulsing valid.
module ffa #(
   parameter int LIMB_W = 51
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
`ifdef FFA_HOLD_VALID_EN
   input  logic         ack,
`endif
   input  logic [254:0] a,
   input  logic [254:0] b,
   output logic [254:0] result,
   output logic         valid,
   output logic         busy
);

   localparam int NLIMB = 255 / LIMB_W;
   localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
   localparam logic [LIMB_W-1:0] P_LOW = {LIMB_W{1'b1}} - LIMB_W'(18);

   typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

   state_t            state;
   state_t            state_next;
   logic [254:0]      a_sr;
   logic [254:0]      b_sr;
   logic [254:0]      s_sr;
   logic [254:0]      d_sr;
   logic [CW-1:0]     cnt;
   logic              carry;
   logic              borrow;
   logic [LIMB_W-1:0] p_limb;
   logic [LIMB_W:0]   sum_w;
   logic [LIMB_W:0]   diff_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN:  if (cnt == CW'(NLIMB - 1)) state_next = DONE;
`ifdef FFA_HOLD_VALID_EN
         DONE: state_next = HOLD;
         HOLD: if (ack) state_next = IDLE;
`else
         DONE: state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
   end

   // One limb of the sum and of (sum - p) per cycle; the final select uses both chains' outgoing bits.
   always_comb begin
      p_limb = (cnt == '0) ? P_LOW : {LIMB_W{1'b1}};
      sum_w  = {1'b0, a_sr[LIMB_W-1:0]} + {1'b0, b_sr[LIMB_W-1:0]}
             + {{LIMB_W{1'b0}}, carry};
      diff_w = {1'b0, sum_w[LIMB_W-1:0]} - {1'b0, p_limb}
             - {{LIMB_W{1'b0}}, borrow};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         s_sr   <= '0;
         d_sr   <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         borrow <= 1'b0;
         result <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
`ifndef FFA_HOLD_VALID_EN
         valid <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  cnt    <= '0;
                  carry  <= 1'b0;
                  borrow <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> LIMB_W;
               b_sr   <= b_sr >> LIMB_W;
               s_sr   <= (s_sr >> LIMB_W) | (255'(sum_w[LIMB_W-1:0]) << (255 - LIMB_W));
               d_sr   <= (d_sr >> LIMB_W) | (255'(diff_w[LIMB_W-1:0]) << (255 - LIMB_W));
               carry  <= sum_w[LIMB_W];
               borrow <= diff_w[LIMB_W];
               cnt    <= cnt + CW'(1);
            end
            // The 256-bit sum is >= p exactly when it overflowed bit 254 or the subtract did not borrow.
            DONE: begin
               result <= (carry || !borrow) ? d_sr : s_sr;
               valid  <= 1'b1;
`ifndef FFA_HOLD_VALID_EN
               busy   <= 1'b0;
`endif
            end
            HOLD: begin
`ifdef FFA_HOLD_VALID_EN
               if (ack) begin
                  valid <= 1'b0;
                  busy  <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ffa.sv
// Scoreboard bench for ffa: stimulus pushes (a+b) mod p expectations, an independent monitor pops them on valid.
module tb_ffa;

   localparam int LIMB_W = 51;
   localparam int NLIMB  = 255 / LIMB_W;
   localparam logic [254:0] P = {255{1'b1}} - 255'd18;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [254:0] a = '0;
   logic [254:0] b = '0;
   logic [254:0] result;
   logic         valid;
   logic         busy;
`ifdef FFA_HOLD_VALID_EN
   logic         ack = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   logic [254:0] expq[$];
   logic         valid_q = 1'b0;
   logic [254:0] held;

   ffa #(.LIMB_W(LIMB_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
`ifdef FFA_HOLD_VALID_EN
      .ack(ack),
`endif
      .a(a),
      .b(b),
      .result(result),
      .valid(valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: plain big-integer addition followed by a reduction against p.
   function automatic logic [254:0] model(input logic [254:0] x, input logic [254:0] y);
      logic [255:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      return s[254:0];
   endfunction

   function automatic logic [254:0] randCanon();
      logic [255:0] t;
      logic [254:0] r;
      do begin
         t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         r = t[254:0];
      end while (r >= P);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [254:0] act, input logic [254:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [254:0] x, input logic [254:0] y);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) checkOutput("wait_not_busy_timeout", 255'(busy), 255'(0));
      a = x;
      b = y;
      start = 1'b1;
      expq.push_back(model(x, y));
      @(posedge clk);
      #1;
      start = 1'b0;
      a = randCanon();
      b = randCanon();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_queue_empty", 255'(expq.size()), 255'(0));
   endtask

   // Monitor: every rising valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         if (valid && !valid_q) begin
            if (expq.size() == 0) begin
               checkOutput("unexpected_valid", 255'(1), 255'(0));
            end else begin
               checkOutput("result", result, expq.pop_front());
            end
            held = result;
         end else if (valid && valid_q) begin
            checkOutput("held_result_stable", result, held);
         end
         valid_q <= valid;
      end
   end

`ifdef FFA_HOLD_VALID_EN
   always begin
      @(negedge clk);
      if (valid && !rst && !ack) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
      end
   end
`endif

   initial begin
      int k;
      logic [254:0] x;
      logic [254:0] y;

      #12;
      rst = 1'b0;
      #3;
      checkOutput("reset_result", result, '0);
      checkOutput("reset_valid", 255'(valid), 255'(0));
      checkOutput("reset_busy", 255'(busy), 255'(0));

      // Simple sum with latency and busy profile.
      applyStimulus(255'd1, 255'd2);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (!valid) checkOutput("busy_during_run", 255'(busy), 255'(1));
      end while (!valid && k < 20);
      checkOutput("latency", 255'(k - 1), 255'(NLIMB + 1));
`ifndef FFA_HOLD_VALID_EN
      checkOutput("busy_at_valid", 255'(busy), 255'(0));
`endif
      drain();

      applyStimulus(P - 255'd1, 255'd1);
      applyStimulus(P - 255'd1, P - 255'd1);
      applyStimulus(255'd1 << 254, 255'd1 << 254);
      applyStimulus('0, '0);
      drain();

      // Start asserted mid-operation is ignored.
      applyStimulus(255'd7, 255'd8);
      repeat (3) @(negedge clk);
      a = 255'd5;
      b = 255'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain();
      repeat (NLIMB + 3) @(negedge clk);
      applyStimulus(255'd5, 255'd5);
      drain();

      // Reset between E2 and E3 aborts the operation.
      applyStimulus(255'd9, 255'd9);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_result", result, '0);
      checkOutput("abort_valid", 255'(valid), 255'(0));
      checkOutput("abort_busy", 255'(busy), 255'(0));
      expq.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (NLIMB + 5) @(negedge clk);
      applyStimulus(255'd3, 255'd4);
      drain();

      // Back-to-back random canonical operands with occasional edge values.
      for (int i = 0; i < 1000; i++) begin
         x = randCanon();
         y = randCanon();
         case ($urandom_range(0, 15))
            0: x = P - 255'd1;
            1: y = '0;
            2: y = P - x;
            default: ;
         endcase
         if (y >= P) y = '0;
         applyStimulus(x, y);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
